board_arbiter: RTL and testbench
================================

# board_arbiter

Owns the 9-cell tic-tac-toe board storage and shares its single access port between the game controller (moves), the display (cell reads) and an internal win/draw scanner. After every accepted move it scans the whole board, then drives `gameIsDone` and `winner` back to the game controller. It sits between `gameController` and the display logic and is the only block that touches board state.

## Interface
Parameters:
- `SCAN_CELLS`, 9, number of board cells scanned; fixed for 3x3 play.

Ports:
- `ph1`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on `ph1` rising edge.
- `clearReq`  in  1  start a new game by clearing the board.
- `wrReq`  in  1  move request from the game controller.
- `wrAddr`  in  4  cell to write, 0..8 valid.
- `wrState`  in  2  cell value to write, X=2'b10 or O=2'b11.
- `wrAck`  out  1  move committed this cycle.
- `wrErr`  out  1  move rejected this cycle.
- `dispReq`  in  1  display read request.
- `dispAddr`  in  4  cell to read.
- `dispAck`  out  1  read granted this cycle.
- `dispData`  out  2  read data, valid the cycle after `dispAck`.
- `busy`  out  1  clear or scan in progress.
- `gameIsDone`  out  1  a line was completed or the board is full.
- `winner`  out  2  X, O, or EMPTY (2'b00) for draw / no result.

## Operation
- Cell encoding: EMPTY=2'b00, X=2'b10, O=2'b11; 2'b01 is never written.
- FSM states: CLEAR, IDLE, SCAN, EVAL.
- CLEAR: writes EMPTY to cells 0..8, one per cycle (9 cycles), clears `gameIsDone` and `winner` on entry, then goes to IDLE.
- IDLE priority: `clearReq` > `wrReq` > `dispReq`.
- `clearReq` is honoured in any state. It aborts an active SCAN/EVAL and enters CLEAR on the next cycle.
- `wrReq` in IDLE:
  - Accepted (`wrAck`=1, cell written, next state SCAN) only if `wrAddr`<=8, the cell is EMPTY, `wrState` is X or O, and `gameIsDone`=0.
  - Otherwise `wrErr`=1, there is no write, and the state stays IDLE.
- The emptiness check uses a shadow copy of the board, 9x2 bits, kept in step with every RAM write.
- `wrReq` outside IDLE gets neither ack nor err. The requester holds the request.
- `dispReq` is granted only in IDLE with no `clearReq` or `wrReq`. If `dispAddr`>8, `dispData`=00.
- SCAN reads cells 0..8 through the RAM port, one address per cycle, and captures each result one cycle later.
- EVAL checks the 8 lines: 3 rows, 3 columns, 2 diagonals.
  - Three equal non-EMPTY cells on a line → `gameIsDone`=1, `winner`=that value.
  - Otherwise, all 9 cells non-EMPTY → `gameIsDone`=1, `winner`=EMPTY.
  - Otherwise both outputs are unchanged. Next state is IDLE.

## Timing
- Reset: the FSM enters CLEAR. All outputs are 0 / 2'b00 in the first cycle after reset. `busy`=1 for the 9 CLEAR cycles.
- `wrAck`, `wrErr` and `dispAck` are combinational in the request cycle. `dispData` is registered and valid 1 cycle later.
- For a move accepted in cycle N:
  - SCAN runs N+1..N+10 (addresses issued N+1..N+9, last capture at N+10).
  - EVAL runs in N+11. `gameIsDone` and `winner` are valid from N+12.
  - `busy`=1 from N+1 to N+11.
- A clear requested in cycle N has `busy`=1 from N+1 to N+9 and is back in IDLE at N+10.
- If reset and `clearReq` arrive together, reset wins (same result).
- If `clearReq` and `wrReq` arrive in the same cycle, the write is dropped with no ack or err.

## Configuration
- `BOARD_ARB_MOVECNT_EN`:
  - When defined, adds output `moveCount` [3:0]. It increments on each `wrAck`, saturates at 9, resets to 0 on reset or on CLEAR entry, and EVAL uses `moveCount`==9 as its draw condition.
  - When undefined, the port is absent and the draw condition comes from the captured cells.

## Structure
- Shared package `ttt_pkg` holds:
  - `cellStateType` enum (EMPTY, X, O).
  - `NUM_CELLS`=9.
  - The 8x3 win-line address table.
  - The arbiter state enum.
- Sub-module `board_ram`: 9x2 single-port RAM with synchronous write and registered read. No reset.

## Test plan
- Reset low for 2 cycles, then release → `busy`=1 for 9 cycles, then `dispReq` at `dispAddr`=4 returns 00.
- Write X to cells 0,1,2, alternating O to 3,4, with each move waiting for `busy`=0 → after the third X, `gameIsDone`=1 and `winner`=2'b10 exactly 12 cycles after `wrAck`.
- Write to an occupied cell 4, then to `wrAddr`=9 → `wrErr`=1, `wrAck`=0, and a display read still returns the original value.
- Draw sequence X0 O1 X2 X3 O4 O5 O6 X7 X8 → `gameIsDone`=1, `winner`=00. A further write gets `wrErr`=1.
- `clearReq` in the 5th SCAN cycle → SCAN aborts, `gameIsDone`=0, all 9 cells read 00 after `busy` drops, and `moveCount`=0 when `BOARD_ARB_MOVECNT_EN` is defined.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell encoding, arbiter FSM states and the win-line table.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b10,
    O     = 2'b11
  } cellStateType;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCAN,
    EVAL
  } arbStateType;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Three cell addresses per line: rows, columns, then both diagonals (line 0 is rightmost).
  localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = {
    {4'd2, 4'd4, 4'd6},
    {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8},
    {4'd1, 4'd4, 4'd7},
    {4'd0, 4'd3, 4'd6},
    {4'd6, 4'd7, 4'd8},
    {4'd3, 4'd4, 4'd5},
    {4'd0, 4'd1, 4'd2}
  };

endpackage

// File: rtl/board_arbiter_if.sv
// Request/response bundle between the game controller / display and board_arbiter.
// With BOARD_ARB_MOVECNT_EN defined the bundle also carries moveCount.
interface board_arbiter_if;

  logic       clearReq;
  logic       wrReq;
  logic [3:0] wrAddr;
  logic [1:0] wrState;
  logic       wrAck;
  logic       wrErr;
  logic       dispReq;
  logic [3:0] dispAddr;
  logic       dispAck;
  logic [1:0] dispData;
  logic       busy;
  logic       gameIsDone;
  logic [1:0] winner;
`ifdef BOARD_ARB_MOVECNT_EN
  logic [3:0] moveCount;
`endif

  modport master (
    output clearReq, wrReq, wrAddr, wrState, dispReq, dispAddr,
`ifdef BOARD_ARB_MOVECNT_EN
    input  moveCount,
`endif
    input  wrAck, wrErr, dispAck, dispData, busy, gameIsDone, winner
  );

  modport slave (
    input  clearReq, wrReq, wrAddr, wrState, dispReq, dispAddr,
`ifdef BOARD_ARB_MOVECNT_EN
    output moveCount,
`endif
    output wrAck, wrErr, dispAck, dispData, busy, gameIsDone, winner
  );

endinterface

// File: rtl/board_ram.sv
// 9x2 single-port board RAM: synchronous write, registered read, no reset.
module board_ram
  import ttt_pkg::*;
(
  input  logic       ph1,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [1:0] wData,
  output logic [1:0] rData
);

  logic [1:0] mem [NUM_CELLS];

  // Read returns the old contents when reading and writing the same cell.
  always_ff @(posedge ph1) begin
    if (we) mem[addr] <= wData;
    rData <= mem[addr];
  end

endmodule

// File: rtl/board_arbiter.sv
// board_arbiter: owns the board RAM and shares its port between moves, display reads and the win/draw scan.
// Define BOARD_ARB_MOVECNT_EN to add a saturating moveCount output that also drives the draw decision.
module board_arbiter
  import ttt_pkg::*;
#(
  parameter int SCAN_CELLS = NUM_CELLS
) (
  input  logic           ph1,
  input  logic           reset,
  board_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_CELL = 4'(SCAN_CELLS - 1);
  localparam logic [3:0] SCAN_END  = 4'(SCAN_CELLS);

  arbStateType state;
  logic [3:0]  cnt;
  logic        busyReg;
  logic        doneReg;
  logic [1:0]  winnerReg;
  logic        dispOk;
  logic [1:0]  shadow [NUM_CELLS];
  logic [1:0]  cap [NUM_CELLS];

  logic        ramWe;
  logic [3:0]  ramAddr;
  logic [1:0]  ramWData;
  logic [1:0]  ramRData;

  logic        idleFree;
  logic        cellEmpty;
  logic        moveOk;
  logic        ackMove;
  logic        ackDisp;
  logic        lineWin;
  logic [1:0]  lineVal;
  logic        drawCond;

`ifdef BOARD_ARB_MOVECNT_EN
  logic [3:0]  moveCountReg;
`endif

  // A pending clear blocks every other grant in the same cycle.
  assign idleFree = (state == IDLE) && !bus.clearReq;

  always_comb begin
    cellEmpty = 1'b0;
    if (bus.wrAddr <= LAST_CELL) cellEmpty = (shadow[bus.wrAddr] == EMPTY);
  end

  assign moveOk  = cellEmpty && ((bus.wrState == X) || (bus.wrState == O)) && !doneReg;
  assign ackMove = idleFree && bus.wrReq && moveOk;
  assign ackDisp = idleFree && !bus.wrReq && bus.dispReq;

  assign bus.wrAck      = ackMove;
  assign bus.wrErr      = idleFree && bus.wrReq && !moveOk;
  assign bus.dispAck    = ackDisp;
  assign bus.dispData   = dispOk ? ramRData : EMPTY;
  assign bus.busy       = busyReg;
  assign bus.gameIsDone = doneReg;
  assign bus.winner     = winnerReg;

  always_comb begin
    ramWe    = 1'b0;
    ramAddr  = 4'd0;
    ramWData = EMPTY;
    case (state)
      CLEAR: begin
        ramWe   = 1'b1;
        ramAddr = cnt;
      end
      IDLE: begin
        if (ackMove) begin
          ramWe    = 1'b1;
          ramAddr  = bus.wrAddr;
          ramWData = bus.wrState;
        end else if (ackDisp && (bus.dispAddr <= LAST_CELL)) begin
          ramAddr = bus.dispAddr;
        end
      end
      SCAN: begin
        if (cnt <= LAST_CELL) ramAddr = cnt;
      end
      default: ;
    endcase
  end

  board_ram uRam (
    .ph1   (ph1),
    .we    (ramWe),
    .addr  (ramAddr),
    .wData (ramWData),
    .rData (ramRData)
  );

  always_ff @(posedge ph1) begin
    if (ramWe) shadow[ramAddr] <= ramWData;
  end

  // Each scan address returns data one cycle later, so the capture slot trails cnt by one.
  always_ff @(posedge ph1) begin
    if ((state == SCAN) && (cnt != 4'd0)) cap[cnt - 4'd1] <= ramRData;
  end

  always_comb begin
    lineWin  = 1'b0;
    lineVal  = EMPTY;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!lineWin && (cap[WIN_LINES[i][0]] != EMPTY) &&
          (cap[WIN_LINES[i][0]] == cap[WIN_LINES[i][1]]) &&
          (cap[WIN_LINES[i][0]] == cap[WIN_LINES[i][2]])) begin
        lineWin = 1'b1;
        lineVal = cap[WIN_LINES[i][0]];
      end
    end
`ifdef BOARD_ARB_MOVECNT_EN
    drawCond = (moveCountReg == 4'd9);
`else
    drawCond = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cap[i] == EMPTY) drawCond = 1'b0;
    end
`endif
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state     <= CLEAR;
      cnt       <= 4'd0;
      busyReg   <= 1'b1;
      doneReg   <= 1'b0;
      winnerReg <= EMPTY;
      dispOk    <= 1'b0;
    end else begin
      dispOk <= ackDisp && (bus.dispAddr <= LAST_CELL);
      if (bus.clearReq) begin
        state     <= CLEAR;
        cnt       <= 4'd0;
        busyReg   <= 1'b1;
        doneReg   <= 1'b0;
        winnerReg <= EMPTY;
      end else begin
        case (state)
          CLEAR: begin
            if (cnt == LAST_CELL) begin
              state   <= IDLE;
              cnt     <= 4'd0;
              busyReg <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          IDLE: begin
            if (ackMove) begin
              state   <= SCAN;
              cnt     <= 4'd0;
              busyReg <= 1'b1;
            end
          end
          SCAN: begin
            if (cnt == SCAN_END) state <= EVAL;
            else cnt <= cnt + 4'd1;
          end
          EVAL: begin
            if (lineWin) begin
              doneReg   <= 1'b1;
              winnerReg <= lineVal;
            end else if (drawCond) begin
              doneReg   <= 1'b1;
              winnerReg <= EMPTY;
            end
            state   <= IDLE;
            busyReg <= 1'b0;
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end

`ifdef BOARD_ARB_MOVECNT_EN
  always_ff @(posedge ph1) begin
    if (!reset || bus.clearReq) moveCountReg <= 4'd0;
    else if (ackMove && (moveCountReg < 4'd9)) moveCountReg <= moveCountReg + 4'd1;
  end

  assign bus.moveCount = moveCountReg;
`endif

endmodule

// File: tb/tb_board_arbiter.sv
// Directed self-checking bench for board_arbiter: reset, wins, rejects, draw and clear-abort.
// Also checks moveCount when BOARD_ARB_MOVECNT_EN is defined.
module tb_board_arbiter;

  logic ph1 = 1'b0;
  logic reset;
  int   testsRun  = 0;
  int   failCount = 0;

  board_arbiter_if bus ();

  board_arbiter #(.SCAN_CELLS(9)) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ph1 = ~ph1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge ph1);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [3:0] addr, input logic [1:0] st);
    bus.wrReq   = req;
    bus.wrAddr  = addr;
    bus.wrState = st;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    if (bus.busy) checkOutput("idleTimeout", 8'(bus.busy), 8'd0);
  endtask

  // Leaves the bench one cycle after the request cycle.
  task automatic doMove(input logic [3:0] addr, input logic [1:0] st, input logic expAck, input string tag);
    waitIdle();
    applyStimulus(1'b1, addr, st);
    #1;
    checkOutput({tag, "_ack"}, 8'(bus.wrAck), 8'(expAck));
    checkOutput({tag, "_err"}, 8'(bus.wrErr), 8'(!expAck));
    step();
    applyStimulus(1'b0, 4'd0, 2'b00);
  endtask

  task automatic readCell(input logic [3:0] addr, input logic [1:0] expData, input string tag);
    bus.dispReq  = 1'b1;
    bus.dispAddr = addr;
    #1;
    checkOutput({tag, "_ack"}, 8'(bus.dispAck), 8'd1);
    step();
    bus.dispReq = 1'b0;
    checkOutput({tag, "_data"}, 8'(bus.dispData), 8'(expData));
  endtask

  task automatic countBusy(input int expCycles, input string tag);
    int n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    checkOutput(tag, 8'(n), 8'(expCycles));
  endtask

  task automatic pulseClear();
    bus.clearReq = 1'b1;
    step();
    bus.clearReq = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    bus.clearReq = 1'b0;
    bus.dispReq  = 1'b0;
    bus.dispAddr = 4'd0;
    applyStimulus(1'b0, 4'd0, 2'b00);

    step();
    step();
    reset = 1'b1;
    checkOutput("reset_busy", 8'(bus.busy), 8'd1);
    checkOutput("reset_done", 8'(bus.gameIsDone), 8'd0);
    checkOutput("reset_winner", 8'(bus.winner), 8'd0);
    checkOutput("reset_dispData", 8'(bus.dispData), 8'd0);
`ifdef BOARD_ARB_MOVECNT_EN
    checkOutput("reset_moveCount", 8'(bus.moveCount), 8'd0);
`endif
    countBusy(9, "reset_clearCycles");
    readCell(4'd4, 2'b00, "reset_cell4");

    // Game 1: X takes the top row while O sits on 3 and 4.
    doMove(4'd0, 2'b10, 1'b1, "g1_x0");
    doMove(4'd3, 2'b11, 1'b1, "g1_o3");
    doMove(4'd1, 2'b10, 1'b1, "g1_x1");
    doMove(4'd4, 2'b11, 1'b1, "g1_o4");
    waitIdle();
    checkOutput("g1_notDone", 8'(bus.gameIsDone), 8'd0);

    doMove(4'd4, 2'b10, 1'b0, "occupied");
    checkOutput("occupied_noScan", 8'(bus.busy), 8'd0);
    doMove(4'd9, 2'b10, 1'b0, "addr9");
    checkOutput("addr9_noScan", 8'(bus.busy), 8'd0);
    doMove(4'd5, 2'b01, 1'b0, "badState");
    readCell(4'd4, 2'b11, "keep_cell4");
    readCell(4'd9, 2'b00, "disp_oob");

    doMove(4'd2, 2'b10, 1'b1, "g1_x2");
    checkOutput("win_busyN1", 8'(bus.busy), 8'd1);
    repeat (10) step();
    checkOutput("win_doneN11", 8'(bus.gameIsDone), 8'd0);
    checkOutput("win_busyN11", 8'(bus.busy), 8'd1);
    step();
    checkOutput("win_doneN12", 8'(bus.gameIsDone), 8'd1);
    checkOutput("win_winnerN12", 8'(bus.winner), 8'h2);
    checkOutput("win_busyN12", 8'(bus.busy), 8'd0);
    doMove(4'd5, 2'b11, 1'b0, "afterWin");

    pulseClear();
    checkOutput("clear_busy", 8'(bus.busy), 8'd1);
    checkOutput("clear_done", 8'(bus.gameIsDone), 8'd0);
    checkOutput("clear_winner", 8'(bus.winner), 8'd0);
    countBusy(9, "clear_cycles");

    // Draw: X0 O1 X2 X3 O4 O5 O6 X7 X8 fills the board with no line.
    doMove(4'd0, 2'b10, 1'b1, "d_x0");
    doMove(4'd1, 2'b11, 1'b1, "d_o1");
    doMove(4'd2, 2'b10, 1'b1, "d_x2");
    doMove(4'd3, 2'b10, 1'b1, "d_x3");
    doMove(4'd4, 2'b11, 1'b1, "d_o4");
    doMove(4'd5, 2'b11, 1'b1, "d_o5");
    doMove(4'd6, 2'b11, 1'b1, "d_o6");
    doMove(4'd7, 2'b10, 1'b1, "d_x7");
    waitIdle();
    checkOutput("draw_notDone8", 8'(bus.gameIsDone), 8'd0);
    doMove(4'd8, 2'b10, 1'b1, "d_x8");
    waitIdle();
    checkOutput("draw_done", 8'(bus.gameIsDone), 8'd1);
    checkOutput("draw_winner", 8'(bus.winner), 8'd0);
`ifdef BOARD_ARB_MOVECNT_EN
    checkOutput("draw_moveCount", 8'(bus.moveCount), 8'd9);
`endif
    doMove(4'd0, 2'b10, 1'b0, "afterDraw");

    pulseClear();
    waitIdle();

    // Abort: rebuild the winning position, then clear during the winning move's scan.
    doMove(4'd0, 2'b10, 1'b1, "a_x0");
    doMove(4'd3, 2'b11, 1'b1, "a_o3");
    doMove(4'd1, 2'b10, 1'b1, "a_x1");
    doMove(4'd4, 2'b11, 1'b1, "a_o4");
    doMove(4'd2, 2'b10, 1'b1, "a_x2");
    applyStimulus(1'b1, 4'd5, 2'b11);
    bus.dispReq  = 1'b1;
    bus.dispAddr = 4'd0;
    #1;
    checkOutput("scan_wrAck", 8'(bus.wrAck), 8'd0);
    checkOutput("scan_wrErr", 8'(bus.wrErr), 8'd0);
    checkOutput("scan_dispAck", 8'(bus.dispAck), 8'd0);
    applyStimulus(1'b0, 4'd0, 2'b00);
    bus.dispReq = 1'b0;
    repeat (4) step();
    bus.clearReq = 1'b1;
    applyStimulus(1'b1, 4'd5, 2'b11);
    #1;
    checkOutput("abort_wrAck", 8'(bus.wrAck), 8'd0);
    checkOutput("abort_wrErr", 8'(bus.wrErr), 8'd0);
    step();
    bus.clearReq = 1'b0;
    applyStimulus(1'b0, 4'd0, 2'b00);
    checkOutput("abort_busy", 8'(bus.busy), 8'd1);
    countBusy(9, "abort_clearCycles");
    checkOutput("abort_done", 8'(bus.gameIsDone), 8'd0);
    checkOutput("abort_winner", 8'(bus.winner), 8'd0);
`ifdef BOARD_ARB_MOVECNT_EN
    checkOutput("abort_moveCount", 8'(bus.moveCount), 8'd0);
`endif
    for (int i = 0; i < 9; i++) begin
      readCell(4'(i), 2'b00, $sformatf("abort_cell%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
